// File: rtl/raptor64_lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM sequencer: state encoding, field widths and defaults.
package raptor64_lmsm_sequencer_pkg;

    localparam int unsigned REG_W          = 5;
    localparam int unsigned CTX_W          = 4;
    localparam int unsigned SEL_W          = CTX_W + REG_W;
    localparam int unsigned MASK_W         = 31;
    localparam int unsigned DAT_W          = 64;
    localparam int unsigned AW_DEFAULT     = 64;
    localparam int unsigned STRIDE_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StNext = 2'd2,
        StDone = 2'd3
    } lmsm_state_e;

endpackage

// File: rtl/raptor64_lmsm_sequencer_if.sv
// Issue, memory and register-file signals of the LM/SM sequencer.
interface raptor64_lmsm_sequencer_if
    import raptor64_lmsm_sequencer_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
);
    logic              start;
    logic              is_lm;
    logic [MASK_W-1:0] mask;
    logic [AW-1:0]     base_adr;
    logic [CTX_W-1:0]  axc;
    logic              abort;
    logic              busy;
    logic              done;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_adr;
    logic              mem_ack;
    logic [DAT_W-1:0]  mem_dat_i;
    logic [SEL_W-1:0]  rs_sel;
    logic              wb_en;
    logic [SEL_W-1:0]  wb_rt;
    logic [DAT_W-1:0]  wb_dat;

    modport master (
        input  start, is_lm, mask, base_adr, axc, abort, mem_ack, mem_dat_i,
        output busy, done, mem_req, mem_we, mem_adr, rs_sel, wb_en, wb_rt, wb_dat
    );

    modport slave (
        output start, is_lm, mask, base_adr, axc, abort, mem_ack, mem_dat_i,
        input  busy, done, mem_req, mem_we, mem_adr, rs_sel, wb_en, wb_rt, wb_dat
    );

endinterface

// File: rtl/raptor64_lmsm_sequencer_lowbit.sv
// Lowest-set-bit encoder: mask bit k maps to register number k+1; valid=0 for an empty mask.
module raptor64_lowbit_enc
    import raptor64_lmsm_sequencer_pkg::*;
(
    input  logic [MASK_W-1:0] i_mask,
    output logic [REG_W-1:0]  o_reg,
    output logic              o_valid
);

    // Scan high-to-low so the lowest set bit is the last one written.
    always_comb begin
        o_reg = '0;
        for (int k = MASK_W - 1; k >= 0; k--) begin
            if (i_mask[k]) begin
                o_reg = REG_W'(k + 1);
            end
        end
    end

    assign o_valid = |i_mask;

endmodule

// File: rtl/raptor64_lmsm_sequencer.sv
// LM/SM sequencer: walks the register mask lowest-bit-first, one memory transfer per register,
// driving the read-port select for stores and the register writeback for loads.
module raptor64_lmsm_sequencer
    import raptor64_lmsm_sequencer_pkg::*;
#(
    parameter int unsigned AW     = AW_DEFAULT,
    parameter int unsigned STRIDE = STRIDE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    raptor64_lmsm_sequencer_if.master  io_bus
);

    lmsm_state_e       r_state;
    lmsm_state_e       w_state_next;
    logic [MASK_W-1:0] r_mask;
    logic [AW-1:0]     r_base;
    logic [CTX_W-1:0]  r_axc;
    logic              r_is_lm;
    logic [REG_W-1:0]  r_count;
    logic              r_wb_en;
    logic [SEL_W-1:0]  r_wb_rt;
    logic [DAT_W-1:0]  r_wb_dat;

    logic [REG_W-1:0]  w_cur;
    logic              w_mask_valid;
    logic              w_req;
    logic              w_issue;
    logic              w_ack_take;
    logic [AW-1:0]     w_adr;

    raptor64_lowbit_enc u_lowbit_enc (
        .i_mask  (r_mask),
        .o_reg   (w_cur),
        .o_valid (w_mask_valid)
    );

    assign w_req      = (r_state == StReq);
    assign w_issue    = (r_state == StIdle) && io_bus.start && !io_bus.abort;
    // An ack coinciding with abort is dropped: no mask/count update, no writeback.
    assign w_ack_take = w_req && io_bus.mem_ack && !io_bus.abort;
    assign w_adr      = r_base + (AW'(r_count) * AW'(STRIDE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_mask   <= '0;
            r_base   <= '0;
            r_axc    <= '0;
            r_is_lm  <= 1'b0;
            r_count  <= '0;
            r_wb_en  <= 1'b0;
            r_wb_rt  <= '0;
            r_wb_dat <= '0;
        end else begin
            r_state <= w_state_next;
            r_wb_en <= 1'b0;
            if (w_issue) begin
                r_mask  <= io_bus.mask;
                r_base  <= io_bus.base_adr;
                r_axc   <= io_bus.axc;
                r_is_lm <= io_bus.is_lm;
                r_count <= '0;
            end
            if (w_ack_take) begin
                r_mask  <= r_mask & (r_mask - MASK_W'(1));
                r_count <= r_count + REG_W'(1);
                if (r_is_lm) begin
                    r_wb_en  <= 1'b1;
                    r_wb_rt  <= {r_axc, w_cur};
                    r_wb_dat <= io_bus.mem_dat_i;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_issue) begin
                    w_state_next = (|io_bus.mask) ? StReq : StDone;
                end
            end
            StReq: begin
                if (io_bus.abort) begin
                    w_state_next = StIdle;
                end else if (io_bus.mem_ack) begin
                    w_state_next = StNext;
                end
            end
            StNext: begin
                if (io_bus.abort) begin
                    w_state_next = StIdle;
                end else begin
                    w_state_next = w_mask_valid ? StReq : StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign io_bus.busy    = (r_state != StIdle);
    assign io_bus.done    = (r_state == StDone);
    assign io_bus.mem_req = w_req;
    assign io_bus.mem_we  = w_req && !r_is_lm;
    assign io_bus.mem_adr = w_req ? w_adr : '0;
    assign io_bus.rs_sel  = w_req ? {r_axc, w_cur} : '0;
    assign io_bus.wb_en   = r_wb_en;
    assign io_bus.wb_rt   = r_wb_rt;
    assign io_bus.wb_dat  = r_wb_dat;

endmodule

// File: tb/tb_raptor64_lmsm_sequencer.sv
// Scoreboard bench for the LM/SM sequencer: stimulus queues expected transfers, writebacks and
// done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_raptor64_lmsm_sequencer;

    localparam int unsigned AW = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    raptor64_lmsm_sequencer_if #(.AW(AW)) bus ();

    raptor64_lmsm_sequencer #(
        .AW     (AW),
        .STRIDE (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct packed {
        logic        we;
        logic [63:0] adr;
        logic [8:0]  rs;
    } mem_exp_t;

    typedef struct packed {
        logic [8:0]  rt;
        logic [63:0] dat;
    } wb_exp_t;

    mem_exp_t exp_mem[$];
    wb_exp_t  exp_wb[$];
    int       exp_done[$];

    int n_tests   = 0;
    int n_fail    = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;
    int n_acks    = 0;
    int lat;

    logic        prev_req = 1'b0;
    logic        prev_we  = 1'b0;
    logic [63:0] prev_adr = '0;
    logic [8:0]  prev_rs  = '0;
    logic        last_acked;
    mem_exp_t    em;
    wb_exp_t     ew;
    int          ed;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endfunction

    function automatic void unexpected(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event, value %0h", name, act);
    endfunction

    // Memory contents seen by the responder.
    function automatic logic [63:0] mem_model(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    function automatic void push_mem(input logic we, input logic [63:0] adr, input logic [8:0] rs);
        exp_mem.push_back('{we: we, adr: adr, rs: rs});
    endfunction

    function automatic void push_wb(input logic [8:0] rt, input logic [63:0] dat);
        exp_wb.push_back('{rt: rt, dat: dat});
    endfunction

    // Monitor first (sees last cycle's ack), then the memory responder.
    always @(negedge clk) begin
        last_acked = prev_req && bus.mem_ack;
        if (last_acked) begin
            check("req gap after ack", 64'(bus.mem_req), 64'(0));
        end
        if (bus.mem_req) begin
            if (prev_req && !last_acked) begin
                check("held mem_adr", bus.mem_adr, prev_adr);
                check("held rs_sel", 64'(bus.rs_sel), 64'(prev_rs));
                check("held mem_we", 64'(bus.mem_we), 64'(prev_we));
            end else if (exp_mem.size() == 0) begin
                unexpected("mem_req", bus.mem_adr);
            end else begin
                em = exp_mem.pop_front();
                check("mem_adr", bus.mem_adr, em.adr);
                check("mem_we", 64'(bus.mem_we), 64'(em.we));
                check("rs_sel", 64'(bus.rs_sel), 64'(em.rs));
            end
        end
        prev_req = bus.mem_req;
        prev_adr = bus.mem_adr;
        prev_rs  = bus.rs_sel;
        prev_we  = bus.mem_we;

        if (bus.wb_en) begin
            if (exp_wb.size() == 0) begin
                unexpected("wb_en", 64'(bus.wb_rt));
            end else begin
                ew = exp_wb.pop_front();
                check("wb_rt", 64'(bus.wb_rt), 64'(ew.rt));
                check("wb_dat", bus.wb_dat, ew.dat);
            end
        end

        if (bus.done) begin
            if (exp_done.size() == 0) begin
                unexpected("done", 64'(1));
            end else begin
                ed = exp_done.pop_front();
            end
        end

        if (rst) begin
            bus.mem_ack   = 1'b0;
            bus.mem_dat_i = '0;
            wait_cnt      = 0;
        end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
        end else if (bus.mem_req) begin
            if (wait_cnt >= ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_dat_i = mem_model(bus.mem_adr);
                n_acks++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Called at a negedge; start is seen by exactly one rising edge.
    task automatic issue(input logic lm, input logic [30:0] m, input logic [63:0] base,
                         input logic [3:0] ctx);
        n_acks       = 0;
        bus.is_lm    = lm;
        bus.mask     = m;
        bus.base_adr = base;
        bus.axc      = ctx;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Returns the cycle (1 = first negedge after the start edge) on which done was seen.
    task automatic wait_idle(input int poke_at, output int done_lat);
        done_lat = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) check("busy after start", 64'(bus.busy), 64'(1));
            if (c == poke_at) begin
                bus.is_lm = 1'b1;
                bus.mask  = 31'h0000_00FF;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done && done_lat < 0) done_lat = c;
            if (!bus.busy) return;
        end
        unexpected("timeout waiting for idle", 64'(0));
    endtask

    task automatic wait_acks(input int target);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (n_acks >= target) return;
        end
        unexpected("timeout waiting for acks", 64'(n_acks));
    endtask

    task automatic check_idle_outputs();
        check("rst busy", 64'(bus.busy), 64'(0));
        check("rst done", 64'(bus.done), 64'(0));
        check("rst mem_req", 64'(bus.mem_req), 64'(0));
        check("rst mem_we", 64'(bus.mem_we), 64'(0));
        check("rst mem_adr", bus.mem_adr, 64'(0));
        check("rst rs_sel", 64'(bus.rs_sel), 64'(0));
        check("rst wb_en", 64'(bus.wb_en), 64'(0));
        check("rst wb_rt", 64'(bus.wb_rt), 64'(0));
        check("rst wb_dat", bus.wb_dat, 64'(0));
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.is_lm    = 1'b0;
        bus.mask     = '0;
        bus.base_adr = '0;
        bus.axc      = '0;
        bus.abort    = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Single-register LM, immediate ack.
        ack_delay = 0;
        push_mem(1'b0, 64'h1000, 9'h041);
        push_wb(9'h041, 64'hC0DE1000_FFFFEFFF);
        exp_done.push_back(1);
        issue(1'b1, 31'h1, 64'h1000, 4'd2);
        wait_idle(0, lat);
        check("lm1 done latency", 64'(lat), 64'(3));

        // SM of r1, r3, r31.
        push_mem(1'b1, 64'h2000, 9'h061);
        push_mem(1'b1, 64'h2008, 9'h063);
        push_mem(1'b1, 64'h2010, 9'h07F);
        exp_done.push_back(2);
        issue(1'b0, 31'h4000_0005, 64'h2000, 4'd3);
        wait_idle(0, lat);
        check("sm3 done latency", 64'(lat), 64'(7));

        // Empty mask: straight to done.
        exp_done.push_back(3);
        issue(1'b1, 31'h0, 64'h9000, 4'd1);
        wait_idle(0, lat);
        check("mask0 done latency", 64'(lat), 64'(1));

        // Delayed ack, with an ignored start poked mid-sequence.
        ack_delay = 3;
        push_mem(1'b1, 64'h4000, 9'h0A2);
        push_mem(1'b1, 64'h4008, 9'h0A3);
        exp_done.push_back(4);
        issue(1'b0, 31'h6, 64'h4000, 4'd5);
        wait_idle(4, lat);
        check("slow sm done latency", 64'(lat), 64'(11));
        check("slow sm ack count", 64'(n_acks), 64'(2));
        repeat (2) @(negedge clk);
        check("ignored start stays idle", 64'(bus.busy), 64'(0));

        // Abort after the second ack of a 4-register LM.
        ack_delay = 1;
        push_mem(1'b0, 64'h3000, 9'h021);
        push_mem(1'b0, 64'h3008, 9'h022);
        push_wb(9'h021, 64'hC0DE3000_FFFFCFFF);
        push_wb(9'h022, 64'hC0DE3008_FFFFCFF7);
        issue(1'b1, 31'hF, 64'h3000, 4'd1);
        wait_acks(2);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (5) @(negedge clk);
        check("abort busy", 64'(bus.busy), 64'(0));
        check("abort ack count", 64'(n_acks), 64'(2));

        // Same sequence cut short by reset.
        push_mem(1'b0, 64'h5000, 9'h0C1);
        push_mem(1'b0, 64'h5008, 9'h0C2);
        push_wb(9'h0C1, 64'hC0DE5000_FFFFAFFF);
        push_wb(9'h0C2, 64'hC0DE5008_FFFFAFF7);
        issue(1'b1, 31'hF, 64'h5000, 4'd6);
        wait_acks(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs();
        repeat (5) @(negedge clk);
        check("rst ack count", 64'(n_acks), 64'(2));

        // Ack arriving in the abort cycle is discarded: no writeback, no done.
        ack_delay = 0;
        push_mem(1'b0, 64'h6000, 9'h001);
        issue(1'b1, 31'h3, 64'h6000, 4'd0);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (4) @(negedge clk);
        check("ack+abort busy", 64'(bus.busy), 64'(0));

        // Start together with abort in idle: nothing happens.
        bus.abort = 1'b1;
        issue(1'b1, 31'h1, 64'h7000, 4'd4);
        bus.abort = 1'b0;
        @(negedge clk);
        check("start+abort busy", 64'(bus.busy), 64'(0));
        repeat (3) @(negedge clk);

        // Address wraps past the top of the space.
        push_mem(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 9'h0E1);
        push_mem(1'b0, 64'h0, 9'h0E2);
        push_wb(9'h0E1, 64'h3F21FFF8_00000007);
        push_wb(9'h0E2, 64'hC0DE0000_FFFFFFFF);
        exp_done.push_back(5);
        issue(1'b1, 31'h3, 64'hFFFF_FFFF_FFFF_FFF8, 4'd7);
        wait_idle(0, lat);
        check("wrap done latency", 64'(lat), 64'(5));

        repeat (3) @(negedge clk);
        check("mem queue drained", 64'(exp_mem.size()), 64'(0));
        check("wb queue drained", 64'(exp_wb.size()), 64'(0));
        check("done queue drained", 64'(exp_done.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
